// File: rtl/player_move_ctrl.sv
// player_move_ctrl: button-to-grid move sequencer (erase -> step -> draw -> cooldown).
// Define MOVE_REPEAT_EN to add per-direction hold-to-repeat counters.
module player_move_ctrl #(
    parameter int GRID_N          = 5,
    parameter int COOLDOWN_FRAMES = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int REPEAT_DELAY    = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       frame_tick,
    input  logic       draw_ack,
    output logic       step_up,
    output logic       step_down,
    output logic       step_left,
    output logic       step_right,
    output logic       erase_req,
    output logic       draw_req,
    output logic [2:0] cell_col,
    output logic [2:0] cell_row,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, ERASE, STEP, DRAW, COOL} state_t;

    localparam logic [2:0] HOME      = 3'(GRID_N / 2);
    localparam logic [2:0] LAST      = 3'(GRID_N - 1);
    localparam logic [7:0] COOL_LAST = 8'(COOLDOWN_FRAMES - 1);

    if (GRID_N < 2 || GRID_N > 8 || COOLDOWN_FRAMES < 1 || COOLDOWN_FRAMES > 255 ||
        SYNC_STAGES < 2 || REPEAT_DELAY < 1 || REPEAT_DELAY > 255) begin : g_bad_cfg
        $error("player_move_ctrl: parameter out of range");
    end

    // Direction vectors are ordered {right, left, down, up}.
    logic [3:0] r_sync [SYNC_STAGES];
    logic [3:0] r_prev;
    logic [3:0] r_pend;
    logic [3:0] r_dir;
    logic [3:0] r_step;
    state_t     r_state;
    logic [7:0] r_cool;
    logic [2:0] r_col;
    logic [2:0] r_row;
    logic       r_erase;
    logic       r_draw;
    logic       r_busy;
    logic [3:0] w_lvl;
    logic [3:0] w_rise;
    logic [3:0] w_rep;
    logic [3:0] w_sel;
    logic [3:0] w_ok;
    logic [3:0] w_take;
    logic       w_legal;

    assign w_lvl  = r_sync[SYNC_STAGES-1];
    assign w_rise = w_lvl & ~r_prev;

    always_comb begin
        w_sel   = r_pend[0] ? 4'b0001 : r_pend[1] ? 4'b0010 :
                  r_pend[2] ? 4'b0100 : r_pend[3] ? 4'b1000 : 4'b0000;
        w_ok    = {r_col != LAST, r_col != 3'd0, r_row != LAST, r_row != 3'd0};
        w_legal = |(w_sel & w_ok);
        // Selected bit is consumed whether legal (serviced) or not (discarded).
        w_take  = (r_state == IDLE && enable) ? w_sel : 4'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
            r_prev <= '0;
            r_pend <= '0;
        end else begin
            r_sync[0] <= {btn_right, btn_left, btn_down, btn_up};
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
            r_prev <= w_lvl;
            r_pend <= enable ? ((r_pend & ~w_take) | w_rise | w_rep) : 4'd0;
        end
    end

`ifdef MOVE_REPEAT_EN
    localparam logic [7:0] REP_LAST = 8'(REPEAT_DELAY - 1);

    logic [7:0] r_hold [4];

    always_comb begin
        for (int d = 0; d < 4; d++) w_rep[d] = w_lvl[d] && frame_tick && r_hold[d] == REP_LAST;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < 4; d++) r_hold[d] <= '0;
        end else begin
            for (int d = 0; d < 4; d++) begin
                if (!w_lvl[d] || w_take[d])
                    r_hold[d] <= '0;
                else if (frame_tick)
                    r_hold[d] <= (r_hold[d] == REP_LAST) ? 8'd0 : r_hold[d] + 8'd1;
            end
        end
    end
`else
    assign w_rep = 4'd0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_dir   <= '0;
            r_step  <= '0;
            r_erase <= 1'b0;
            r_draw  <= 1'b0;
            r_busy  <= 1'b0;
            r_cool  <= '0;
            r_col   <= HOME;
            r_row   <= HOME;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable && w_legal) begin
                        r_state <= ERASE;
                        r_dir   <= w_sel;
                        r_erase <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ERASE: begin
                    if (draw_ack) begin
                        r_state <= STEP;
                        r_erase <= 1'b0;
                        r_step  <= r_dir;
                    end
                end
                STEP: begin
                    r_state <= DRAW;
                    r_step  <= '0;
                    r_draw  <= 1'b1;
                    r_row   <= r_row - {2'b0, r_dir[0]} + {2'b0, r_dir[1]};
                    r_col   <= r_col - {2'b0, r_dir[2]} + {2'b0, r_dir[3]};
                end
                DRAW: begin
                    if (draw_ack) begin
                        r_state <= COOL;
                        r_draw  <= 1'b0;
                    end
                end
                COOL: begin
                    if (frame_tick) begin
                        if (r_cool == COOL_LAST) begin
                            r_state <= IDLE;
                            r_cool  <= '0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cool <= r_cool + 8'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign {step_right, step_left, step_down, step_up} = r_step;
    assign erase_req = r_erase;
    assign draw_req  = r_draw;
    assign cell_col  = r_col;
    assign cell_row  = r_row;
    assign busy      = r_busy;
endmodule

// File: tb/tb_player_move_ctrl.sv
// tb_player_move_ctrl: directed test of player_move_ctrl with a delayed/immediate-ack renderer model.
module tb_player_move_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       frame_tick = 1'b0;
    logic       draw_ack;
    logic       step_up, step_down, step_left, step_right;
    logic       erase_req, draw_req, busy;
    logic [2:0] cell_col, cell_row;

    int total = 0;
    int bad = 0;

    player_move_ctrl dut (
        .clk(clk), .reset(reset), .enable(enable),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .frame_tick(frame_tick), .draw_ack(draw_ack),
        .step_up(step_up), .step_down(step_down), .step_left(step_left), .step_right(step_right),
        .erase_req(erase_req), .draw_req(draw_req),
        .cell_col(cell_col), .cell_row(cell_row), .busy(busy)
    );

    always #5 clk = ~clk;

    // Renderer: ack_dly cycles after a request rises, or combinationally when ack_dly is 0.
    int   ack_dly = 3;
    int   ack_cnt = 0;
    logic r_ack = 1'b0;
    assign draw_ack = (ack_dly == 0) ? (erase_req | draw_req) : r_ack;
    always @(posedge clk) begin
        if (reset || !(erase_req || draw_req) || r_ack) begin
            ack_cnt <= 0;
            r_ack   <= 1'b0;
        end else begin
            ack_cnt <= ack_cnt + 1;
            r_ack   <= (ack_cnt + 1 == ack_dly);
        end
    end

    int   n_up = 0, n_dn = 0, n_lf = 0, n_rt = 0, n_er = 0, n_dr = 0, viol = 0;
    logic p_er = 1'b0, p_dr = 1'b0, busy_seen = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            n_up += int'(step_up);
            n_dn += int'(step_down);
            n_lf += int'(step_left);
            n_rt += int'(step_right);
            if (erase_req && !p_er) n_er++;
            if (draw_req && !p_dr) n_dr++;
            if (busy) busy_seen = 1'b1;
            if (!$onehot0({step_up, step_down, step_left, step_right})) viol++;
        end
        p_er = erase_req;
        p_dr = draw_req;
    end

    task automatic clr();
        n_up = 0; n_dn = 0; n_lf = 0; n_rt = 0; n_er = 0; n_dr = 0; busy_seen = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
            cyc(1);
        end
    endtask

    task automatic set_btn(input int d, input logic v);
        case (d)
            0: btn_up = v;
            1: btn_down = v;
            2: btn_left = v;
            default: btn_right = v;
        endcase
    endtask

    task automatic do_move(input int d);
        set_btn(d, 1'b1);
        cyc(3);
        set_btn(d, 1'b0);
        cyc(20);
        frames(4);
        cyc(2);
    endtask

    function automatic logic pick(input int w);
        return (w == 0) ? erase_req : (w == 1) ? draw_req : busy;
    endfunction

    task automatic wait_sig(input string tag, input int w, input int lim);
        int k = 0;
        while (!pick(w) && k < lim) begin
            cyc(1);
            k++;
        end
        chk(tag, 32'(pick(w)), 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);
    endtask

    initial begin
        cyc(2);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_erase", 32'(erase_req), 0);
        chk("rst_draw", 32'(draw_req), 0);
        chk("rst_steps", 32'({step_up, step_down, step_left, step_right}), 0);
        chk("rst_col", 32'(cell_col), 2);
        chk("rst_row", 32'(cell_row), 2);
        reset = 1'b0;
        cyc(1);

        clr();
        btn_right = 1'b1;
        cyc(3);
        chk("t1_erase_early", 32'(erase_req), 0);
        cyc(1);
        chk("t1_erase_lat", 32'(erase_req), 1);
        chk("t1_busy", 32'(busy), 1);
        cyc(6);
        btn_right = 1'b0;
        cyc(10);
        chk("t1_col", 32'(cell_col), 3);
        chk("t1_n_rt", n_rt, 1);
        chk("t1_n_er", n_er, 1);
        chk("t1_n_dr", n_dr, 1);
        chk("t1_req_low", 32'({erase_req, draw_req}), 0);
        frames(3);
        chk("t1_busy_cool", 32'(busy), 1);
        frames(1);
        chk("t1_busy_idle", 32'(busy), 0);
        chk("t1_other_steps", n_up + n_dn + n_lf, 0);

        do_reset();
        clr();
        btn_up = 1'b1;
        btn_left = 1'b1;
        cyc(3);
        btn_up = 1'b0;
        btn_left = 1'b0;
        cyc(20);
        chk("t2_row_first", 32'(cell_row), 1);
        chk("t2_col_first", 32'(cell_col), 2);
        chk("t2_n_lf_first", n_lf, 0);
        frames(4);
        cyc(20);
        chk("t2_col", 32'(cell_col), 1);
        chk("t2_row", 32'(cell_row), 1);
        chk("t2_pulses", n_up + n_dn + n_lf + n_rt, 2);
        frames(4);
        cyc(2);
        chk("t2_busy", 32'(busy), 0);

        do_reset();
        do_move(3);
        chk("t3_col3", 32'(cell_col), 3);
        do_move(3);
        chk("t3_col4", 32'(cell_col), 4);
        clr();
        btn_right = 1'b1;
        cyc(3);
        btn_right = 1'b0;
        cyc(10);
        chk("t3_n_er", n_er, 0);
        chk("t3_n_rt", n_rt, 0);
        chk("t3_busy_seen", 32'(busy_seen), 0);
        chk("t3_col", 32'(cell_col), 4);

        clr();
        btn_up = 1'b1;
        cyc(3);
        btn_up = 1'b0;
        wait_sig("t4_draw", 1, 20);
        btn_down = 1'b1;
        cyc(3);
        btn_down = 1'b0;
        cyc(8);
        chk("t4_row_up", 32'(cell_row), 1);
        chk("t4_busy", 32'(busy), 1);
        chk("t4_n_dn_early", n_dn, 0);
        frames(4);
        cyc(20);
        chk("t4_row_down", 32'(cell_row), 2);
        chk("t4_n_dn", n_dn, 1);
        chk("t4_n_up", n_up, 1);
        chk("t4_col", 32'(cell_col), 4);
        frames(4);
        cyc(2);
        chk("t4_busy_end", 32'(busy), 0);

        clr();
        btn_left = 1'b1;
        wait_sig("t5_erase", 0, 20);
        #2;
        reset = 1'b1;
        btn_left = 1'b0;
        #1;
        chk("t5_erase_async", 32'(erase_req), 0);
        chk("t5_busy_async", 32'(busy), 0);
        chk("t5_col_async", 32'(cell_col), 2);
        chk("t5_row_async", 32'(cell_row), 2);
        cyc(2);
        reset = 1'b0;
        cyc(20);
        chk("t5_n_lf", n_lf, 0);
        chk("t5_erase_after", n_er, 0);
        chk("t5_busy_after", 32'(busy), 0);

        do_move(0);
        do_move(0);
        chk("t6_row0", 32'(cell_row), 0);
        ack_dly = 0;
        clr();
        btn_down = 1'b1;
        cyc(3);
        chk("t6_erase_early", 32'(erase_req), 0);
        cyc(1);
        chk("t6_erase", 32'(erase_req), 1);
        chk("t6_ack", 32'(draw_ack), 1);
        cyc(1);
        chk("t6_step", 32'(step_down), 1);
        chk("t6_erase_off", 32'(erase_req), 0);
        cyc(1);
        chk("t6_draw", 32'(draw_req), 1);
        chk("t6_step_off", 32'(step_down), 0);
        chk("t6_row1", 32'(cell_row), 1);
        frames(40);
        btn_down = 1'b0;
        frames(6);
        chk("t6_busy_end", 32'(busy), 0);
`ifdef MOVE_REPEAT_EN
        chk("t6_row_rep", 32'(cell_row), 4);
        chk("t6_n_dn_rep", n_dn, 4);
`else
        chk("t6_row_once", 32'(cell_row), 1);
        chk("t6_n_dn_once", n_dn, 1);
`endif

        clr();
        enable = 1'b0;
        btn_up = 1'b1;
        cyc(3);
        btn_up = 1'b0;
        cyc(5);
        chk("en_off_n_er", n_er, 0);
        enable = 1'b1;
        cyc(8);
        chk("en_on_no_stale", 32'(busy_seen), 0);
        chk("en_steps", n_up, 0);

        chk("step_onehot", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/player_move_ctrl.md
Name: player_move_ctrl

Overview:
Sequencer between the raw direction buttons and the grid-stepping player position register.
- Synchronises and edge-detects the four buttons and arbitrates simultaneous presses.
- Suppresses moves that would leave the GRID_N x GRID_N grid.
- Runs each legal move as erase-old-sprite -> single step pulse -> draw-new-sprite, with a req/ack handshake to the sprite renderer.
- Enforces a frame-based cooldown between moves.

Parameters:
GRID_N, 5, grid cells per side (2..8); the home cell is GRID_N/2 (integer divide).
COOLDOWN_FRAMES, 4, frame_tick pulses counted in COOL before the next move may start (1..255).
SYNC_STAGES, 2, synchroniser flops per button (>=2).
REPEAT_DELAY, 12, frame_tick pulses of continuous hold before auto-repeat (used only with the optional feature; 1..255).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
enable  in  1  accept new moves (e.g. player's turn)
btn_up, btn_down, btn_left, btn_right  in  1 each  raw asynchronous buttons, active-high
frame_tick  in  1  single-cycle pulse once per video frame
draw_ack  in  1  renderer completion pulse for erase_req/draw_req
step_up, step_down, step_left, step_right  out  1 each  single-cycle move pulses to the position register
erase_req  out  1  request erase of sprite at current cell
draw_req  out  1  request draw of sprite at current cell
cell_col  out  3  current column, 0..GRID_N-1
cell_row  out  3  current row, 0..GRID_N-1 (row 0 = top)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, any time, including mid-sequence): state=IDLE, all outputs 0, cell_col=cell_row=GRID_N/2, pending bits 0, sync/edge flops 0, cooldown counter 0.
- Input path: each button passes through SYNC_STAGES flops. A rising edge of the synced level sets that direction's pending bit. The bit stays set until serviced or discarded. A repeat edge while the bit is already set is absorbed.
- Pending bits are captured in every state, so at most one queued move per direction.
- enable=0: all pending bits clear every cycle and IDLE does not start a move. A sequence already in progress completes normally.
- Arbitration, IDLE only: fixed priority up > down > left > right among pending bits. Only the selected bit is cleared.
- Legality check on the selected direction:
  - Illegal: up at row 0, down at row GRID_N-1, left at col 0, right at col GRID_N-1.
  - An illegal request clears its pending bit, stays in IDLE, and produces no pulses. Next-priority bits are evaluated the following cycle.
- States:
  - IDLE -> ERASE when a legal direction is selected; the direction is latched.
  - ERASE: erase_req=1, registered and asserted the cycle after entry. It holds until a cycle with draw_ack=1, then deasserts and the block goes to STEP.
  - STEP: exactly one cycle. The latched step_* pulse is high, and cell_row/cell_col update by +/-1 on the same edge that ends STEP. Then DRAW.
  - DRAW: draw_req=1 until draw_ack=1, then COOL. cell_* already show the new cell.
  - COOL: counter counts frame_tick pulses. On the COOLDOWN_FRAMES-th pulse -> IDLE with counter cleared.
- Minimum move latency with immediate acks: press synced -> erase_req in 2 cycles.
- draw_ack outside ERASE/DRAW is ignored. draw_ack on the cycle erase_req first asserts counts as the ack.
- step_* signals are mutually exclusive and never high outside STEP.
- busy = (state != IDLE).

Optional Feature:
MOVE_REPEAT_EN
- Defined: a per-direction hold counter counts frame_tick while the synced button stays high. It clears on release or when that direction's move is serviced. Reaching REPEAT_DELAY sets the pending bit again and restarts the count, giving auto-repeat while held.
- Undefined: no hold counters are built. Only rising edges set pending bits, so a held button moves exactly once.

Test Plan:
1. Reset, then press btn_right for 10 cycles; renderer acks 3 cycles after each req; 4 frame_ticks -> erase_req, one step_right pulse, draw_req, cell_col 2->3, busy low after the 4th tick.
2. Press btn_up and btn_left in the same cycle -> up serviced first (row 2->1). After cooldown, left serviced (col 2->1). Exactly two pulses total.
3. From col 4, press btn_right -> no erase_req/step pulses, busy stays 0, pending cleared, cell_col stays 4.
4. Press btn_down during DRAW of a prior move -> queued. After COOL it is serviced without a new press: row +1.
5. Assert reset while in ERASE with erase_req=1 -> erase_req 0 asynchronously, cell_col=cell_row=2, state IDLE. No step pulse after reset release.
6. With MOVE_REPEAT_EN: hold btn_down for 40 frame_ticks from row 0 with instant acks -> moves at press, then every 12 ticks, stopping at row 4. Without the macro: one move only (row 0->1).
